arbitro_mux_2bits: RTL
======================

ARBITRO_MUX_2BITS -- requirements
Module: arbitro_mux_2bits

Interface
REQ-001 Parameter TEMPO_MAX, default 8, maximum consecutive grant cycles before preemption when the other requester is waiting; legal range 2..255.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 req1  input  1  requester 1 asks for the shared 2-bit path (MUX in1 side).
REQ-005 req2  input  1  requester 2 asks for the shared 2-bit path (MUX in2 side).
REQ-006 fim1  input  1  requester 1 releases the path; honoured only while gnt1=1.
REQ-007 fim2  input  1  requester 2 releases the path; honoured only while gnt2=1.
REQ-008 gnt1  output  1  registered grant to requester 1.
REQ-009 gnt2  output  1  registered grant to requester 2.
REQ-010 controle  output  1  registered MUX select: 0 selects in1, 1 selects in2.
REQ-011 ocupado  output  1  registered, equals gnt1 OR gnt2.
REQ-012 preempcao  output  1  registered one-cycle pulse when a grant is removed by timeout.

Function
REQ-013 The FSM SHALL have exactly three states: LIVRE, CONCEDE1, CONCEDE2; gnt1=1 only in CONCEDE1, gnt2=1 only in CONCEDE2.
REQ-014 A priority bit ultimo SHALL record the last requester granted (0=req1, 1=req2) and SHALL update on every entry into CONCEDE1/CONCEDE2.
REQ-015 LIVRE: req1 only -> CONCEDE1; req2 only -> CONCEDE2; both -> the requester not equal to ultimo; neither -> stay LIVRE.
REQ-016 Grant latency SHALL be exactly one cycle: request sampled at edge N, gnt visible after edge N.
REQ-017 controle SHALL be 0 in CONCEDE1, 1 in CONCEDE2, and SHALL hold its previous value in LIVRE.
REQ-018 A 8-bit cycle counter SHALL clear on entry into any CONCEDE state and increment each cycle in it, saturating at TEMPO_MAX-1.
REQ-019 CONCEDE1 release condition: fim1=1 or req1=0; same for CONCEDE2 with fim2/req2.
REQ-020 On release from CONCEDEx: if the other requester is asserted -> directly to the other CONCEDE state (no LIVRE cycle); else -> LIVRE.
REQ-021 Timeout: in CONCEDEx with counter = TEMPO_MAX-1 and other requester asserted and no release -> other CONCEDE state, preempcao=1 for that one cycle.
REQ-022 Counter at TEMPO_MAX-1 with the other requester idle SHALL keep the grant, no preemption, counter saturated.
REQ-023 Release and timeout in the same cycle SHALL count as release: preempcao stays 0.
REQ-024 fim1/fim2 asserted without the corresponding grant SHALL be ignored.
REQ-025 gnt1 and gnt2 SHALL never be 1 in the same cycle; controle SHALL never change while ocupado=1 except on a grant handoff edge.
REQ-026 preempcao SHALL be 0 in every cycle not immediately following a timeout transition.

Reset
REQ-027 With reset=1 at an edge: state LIVRE, gnt1=0, gnt2=0, controle=0, ocupado=0, preempcao=0, counter=0, ultimo=1 (req1 wins first tie).
REQ-028 Reset SHALL override every other input, including mid-grant; outputs reach reset values after that same edge.
REQ-029 After reset deasserts, first grant SHALL follow REQ-015/REQ-016 with no extra idle cycle.

Verification
REQ-030 Reset, then req1=req2=1 at edge 1 -> after edge 1 gnt1=1, controle=0, ocupado=1; fim1=1 at edge 3 -> after edge 3 gnt2=1, controle=1, no LIVRE cycle.
REQ-031 TEMPO_MAX=4, req1 held, req2 raised one cycle after gnt1 -> gnt1 held 4 cycles, then gnt2=1 and preempcao=1 for exactly one cycle.
REQ-032 TEMPO_MAX=4, req1 held alone for 10 cycles -> gnt1 stays 1, preempcao stays 0, counter saturated at 3.
REQ-033 gnt2 active, fim2=1 and req1=0 -> LIVRE next cycle, ocupado=0, controle stays 1; fim1=1 while idle -> no effect.
REQ-034 gnt1 active, reset=1 for one edge with req2=1 -> after edge gnt1=gnt2=0, controle=0; next edge gnt2=1.
REQ-035 Random req/fim traffic 10000 cycles -> gnt1 AND gnt2 never 1, controle matches active grant, ties alternate per ultimo.

Source files
------------

// File: rtl/arbitro_mux_2bits_if.sv
// Request/release/grant bundle shared by the two requesters
// and the 2-bit path arbiter.
interface arbitro_mux_2bits_if;
   logic req1;
   logic req2;
   logic fim1;
   logic fim2;
   logic gnt1;
   logic gnt2;
   logic controle;
   logic ocupado;
   logic preempcao;

   modport master (
      output req1, req2, fim1, fim2,
      input  gnt1, gnt2, controle, ocupado, preempcao
   );

   modport slave (
      input  req1, req2, fim1, fim2,
      output gnt1, gnt2, controle, ocupado, preempcao
   );
endinterface

// File: rtl/arbitro_mux_2bits.sv
// Two-requester arbiter for a shared 2-bit MUX path with
// alternating tie priority and timeout preemption.
module arbitro_mux_2bits #(
   parameter int TEMPO_MAX = 8
) (
   input logic clock,
   input logic reset,
   arbitro_mux_2bits_if.slave bus
);
   typedef enum logic [1:0] {
      LIVRE,
      CONCEDE1,
      CONCEDE2
   } estado_t;

   localparam logic [7:0] LIMITE = 8'(TEMPO_MAX - 1);

   estado_t estado, estado_n;
   logic [7:0] cnt, cnt_n;
   logic ultimo, ultimo_n;
   logic controle, controle_n;
   logic preempcao, preempcao_n;
   logic solta, expira;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= LIVRE;
         cnt       <= '0;
         ultimo    <= 1'b1;
         controle  <= 1'b0;
         preempcao <= 1'b0;
      end else begin
         estado    <= estado_n;
         cnt       <= cnt_n;
         ultimo    <= ultimo_n;
         controle  <= controle_n;
         preempcao <= preempcao_n;
      end
   end

   always_comb begin
      estado_n    = estado;
      cnt_n       = cnt;
      ultimo_n    = ultimo;
      controle_n  = controle;
      preempcao_n = 1'b0;
      solta       = 1'b0;
      expira      = 1'b0;
      unique case (estado)
         LIVRE: begin
            // on a tie the requester not served last wins
            if (bus.req1 && (!bus.req2 || ultimo)) begin
               estado_n   = CONCEDE1;
               cnt_n      = '0;
               ultimo_n   = 1'b0;
               controle_n = 1'b0;
            end else if (bus.req2) begin
               estado_n   = CONCEDE2;
               cnt_n      = '0;
               ultimo_n   = 1'b1;
               controle_n = 1'b1;
            end
         end
         CONCEDE1: begin
            solta  = bus.fim1 || !bus.req1;
            expira = (cnt == LIMITE) && bus.req2;
            if (solta || expira) begin
               if (bus.req2) begin
                  estado_n    = CONCEDE2;
                  cnt_n       = '0;
                  ultimo_n    = 1'b1;
                  controle_n  = 1'b1;
                  preempcao_n = !solta;
               end else begin
                  estado_n = LIVRE;
               end
            end else if (cnt != LIMITE) begin
               cnt_n = cnt + 8'd1;
            end
         end
         CONCEDE2: begin
            solta  = bus.fim2 || !bus.req2;
            expira = (cnt == LIMITE) && bus.req1;
            if (solta || expira) begin
               if (bus.req1) begin
                  estado_n    = CONCEDE1;
                  cnt_n       = '0;
                  ultimo_n    = 1'b0;
                  controle_n  = 1'b0;
                  preempcao_n = !solta;
               end else begin
                  estado_n = LIVRE;
               end
            end else if (cnt != LIMITE) begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            estado_n = LIVRE;
         end
      endcase
   end

   assign bus.gnt1      = (estado == CONCEDE1);
   assign bus.gnt2      = (estado == CONCEDE2);
   assign bus.ocupado   = (estado != LIVRE);
   assign bus.controle  = controle;
   assign bus.preempcao = preempcao;
endmodule
